proc_multicycle: RTL and testbench

//  Parametrised multicycle processor (successor to the 4-instruction mv/mvi/add/sub core).

---
 rtl/proc_multicycle.sv | 234 +++++++++++++++++++++++
 tb/tb_proc_multicycle.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_multicycle.sv
// proc_multicycle: multicycle processor on a shared bus, with a load/store memory port.
// Clock/Resetn(async, active-low), Run, DIN -> Done, Bus, ADDR, DOUT, W. `PROC_MVNZ_EN enables mvnz.
module proc_multicycle #(
  parameter int WIDTH = 16,
  parameter int RBITS = 3,
  parameter int AW    = 5
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Run,
  input  logic [WIDTH-1:0] DIN,
  output logic             Done,
  output logic [WIDTH-1:0] Bus,
  output logic [AW-1:0]    ADDR,
  output logic [WIDTH-1:0] DOUT,
  output logic             W
);

  localparam int NREG = 2**RBITS;
  localparam int IW   = 3 + 2*RBITS;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_LD   = 3'b100,
    OP_ST   = 3'b101,
    OP_MVNZ = 3'b110,
    OP_AND  = 3'b111
  } op_t;

  state_t state, state_nx;

  logic [IW-1:0]    ir;
  logic [WIDTH-1:0] rf [NREG];
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] g_q;
  logic [WIDTH-1:0] alu;

  op_t              op;
  logic [RBITS-1:0] rx;
  logic [RBITS-1:0] ry;

  assign op = op_t'(ir[IW-1 -: 3]);
  assign rx = ir[RBITS +: RBITS];
  assign ry = ir[0 +: RBITS];

  // one-hot instruction class
  logic is_mv, is_mvi, is_alu, is_ld, is_st, is_mvnz;

  assign is_mv   = (op == OP_MV);
  assign is_mvi  = (op == OP_MVI);
  assign is_alu  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  assign is_ld   = (op == OP_LD);
  assign is_st   = (op == OP_ST);
  assign is_mvnz = (op == OP_MVNZ);

`ifdef PROC_MVNZ_EN
  logic g_nz;
  assign g_nz = |g_q;
`endif

  // bus sources and register enables
  logic             rout;
  logic [RBITS-1:0] rsel;
  logic             gout;
  logic             rin;
  logic             ain;
  logic             gin;
  logic             ir_in;
  logic             addr_in;
  logic             dout_in;
  logic             w_set;

  // DIN is the fallback source, so it needs no select
  assign Bus = rout ? rf[rsel] :
               gout ? g_q      :
                      DIN;

  always_comb begin
    alu = a_q + Bus;
    case (op)
      OP_SUB:  alu = a_q - Bus;
      OP_AND:  alu = a_q & Bus;
      default: alu = a_q + Bus;
    endcase
  end

  always_comb begin
    state_nx = state;
    rout     = 1'b0;
    rsel     = ry;
    gout     = 1'b0;
    rin      = 1'b0;
    ain      = 1'b0;
    gin      = 1'b0;
    ir_in    = 1'b0;
    addr_in  = 1'b0;
    dout_in  = 1'b0;
    w_set    = 1'b0;
    Done     = 1'b0;
    unique case (state)
      T0: begin
        if (Run) begin
          ir_in    = 1'b1;
          state_nx = T1;
        end
      end
      T1: begin
        unique case (1'b1)
          is_mv: begin
            rout     = 1'b1;
            rin      = 1'b1;
            Done     = 1'b1;
            state_nx = T0;
          end
          is_mvi: begin
            rin      = 1'b1;
            Done     = 1'b1;
            state_nx = T0;
          end
          is_alu: begin
            rout     = 1'b1;
            rsel     = rx;
            ain      = 1'b1;
            state_nx = T2;
          end
          is_ld, is_st: begin
            rout     = 1'b1;
            addr_in  = 1'b1;
            state_nx = T2;
          end
          is_mvnz: begin
`ifdef PROC_MVNZ_EN
            if (g_nz) begin
              rout = 1'b1;
              rin  = 1'b1;
            end
`endif
            Done     = 1'b1;
            state_nx = T0;
          end
          default: state_nx = T0;
        endcase
      end
      T2: begin
        unique case (1'b1)
          is_alu: begin
            rout     = 1'b1;
            gin      = 1'b1;
            state_nx = T3;
          end
          // one-cycle memory latency
          is_ld: state_nx = T3;
          is_st: begin
            rout     = 1'b1;
            rsel     = rx;
            dout_in  = 1'b1;
            w_set    = 1'b1;
            state_nx = T3;
          end
          default: state_nx = T0;
        endcase
      end
      T3: begin
        unique case (1'b1)
          is_alu: begin
            gout     = 1'b1;
            rin      = 1'b1;
            Done     = 1'b1;
            state_nx = T0;
          end
          is_ld: begin
            rin      = 1'b1;
            Done     = 1'b1;
            state_nx = T0;
          end
          is_st: begin
            Done     = 1'b1;
            state_nx = T0;
          end
          default: state_nx = T0;
        endcase
      end
      default: state_nx = T0;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= T0;
      ir    <= '0;
      a_q   <= '0;
      g_q   <= '0;
      ADDR  <= '0;
      DOUT  <= '0;
      W     <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else begin
      state <= state_nx;
      // W is high only for the cycle after the store's T2
      W     <= w_set;
      if (ir_in) begin
        ir <= DIN[IW-1:0];
      end
      if (ain) begin
        a_q <= Bus;
      end
      if (gin) begin
        g_q <= alu;
      end
      if (addr_in) begin
        ADDR <= Bus[AW-1:0];
      end
      if (dout_in) begin
        DOUT <= Bus;
      end
      if (rin) begin
        rf[rx] <= Bus;
      end
    end
  end

endmodule

// File: tb/tb_proc_multicycle.sv
// tb_proc_multicycle: scoreboard bench for proc_multicycle.
// Driver issues instructions against a reference model; monitor checks on Done.
module tb_proc_multicycle;

  localparam int WIDTH = 16;
  localparam int RBITS = 3;
  localparam int AW    = 5;

  localparam logic [2:0] MV   = 3'b000;
  localparam logic [2:0] MVI  = 3'b001;
  localparam logic [2:0] ADD  = 3'b010;
  localparam logic [2:0] SUB  = 3'b011;
  localparam logic [2:0] LD   = 3'b100;
  localparam logic [2:0] ST   = 3'b101;
  localparam logic [2:0] MVNZ = 3'b110;
  localparam logic [2:0] AND  = 3'b111;

  logic             Clock = 1'b0;
  logic             Resetn;
  logic             Run;
  logic [WIDTH-1:0] DIN;
  logic             Done;
  logic [WIDTH-1:0] Bus;
  logic [AW-1:0]    ADDR;
  logic [WIDTH-1:0] DOUT;
  logic             W;

  proc_multicycle #(
    .WIDTH(WIDTH),
    .RBITS(RBITS),
    .AW(AW)
  ) dut (
    .Clock(Clock),
    .Resetn(Resetn),
    .Run(Run),
    .DIN(DIN),
    .Done(Done),
    .Bus(Bus),
    .ADDR(ADDR),
    .DOUT(DOUT),
    .W(W)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] bus;
    logic [4:0]  addr;
    logic [15:0] dout;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          nvec = 0;
  int          nfail = 0;
  int          cyc = 0;
  logic [15:0] regs[8];
  logic [15:0] gmod;
  logic [15:0] mem[32];

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // monitor
  always @(negedge Clock) begin
    if (Resetn === 1'b1) begin
      if (Done === 1'b1) begin
        chk("done_expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("done_cycle", cyc, mon_e.cyc);
          chk("bus", Bus, mon_e.bus);
          chk("w_at_done", W, 32'(mon_e.op == ST));
          if (mon_e.op == ST) begin
            chk("st_addr", ADDR, mon_e.addr);
            chk("st_dout", DOUT, mon_e.dout);
          end
        end
      end else begin
        chk("w_idle", W, 0);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) regs[i] = '0;
    gmod = '0;
  endtask

  // entry/exit: #1 after a posedge, DUT in T0
  task automatic exec(input logic [2:0] op, input logic [2:0] x,
                      input logic [2:0] y, input logic [15:0] imm);
    exp_t        e;
    int          steps;
    logic [15:0] din_s[4];
    logic [15:0] d;
    for (int i = 0; i < 4; i++) din_s[i] = 16'($urandom);
    steps  = (op == MV || op == MVI || op == MVNZ) ? 1 : 3;
    e.op   = op;
    e.addr = '0;
    e.dout = '0;
    e.bus  = '0;
    e.cyc  = cyc + steps;
    case (op)
      MV: begin
        regs[x] = regs[y];
        e.bus   = regs[x];
      end
      MVI: begin
        din_s[1] = imm;
        regs[x]  = imm;
        e.bus    = imm;
      end
      ADD, SUB, AND: begin
        if (op == ADD)      d = regs[x] + regs[y];
        else if (op == SUB) d = regs[x] - regs[y];
        else                d = regs[x] & regs[y];
        regs[x] = d;
        gmod    = d;
        e.bus   = d;
      end
      LD: begin
        d        = mem[regs[y][4:0]];
        din_s[3] = d;
        regs[x]  = d;
        e.bus    = d;
      end
      ST: begin
        e.addr      = regs[y][4:0];
        e.dout      = regs[x];
        mem[e.addr] = regs[x];
        e.bus       = din_s[3];
      end
      default: begin
`ifdef PROC_MVNZ_EN
        if (gmod != 0) begin
          regs[x] = regs[y];
          e.bus   = regs[y];
        end else begin
          e.bus = din_s[1];
        end
`else
        e.bus = din_s[1];
`endif
      end
    endcase
    sb.push_back(e);
    Run = 1'b1;
    DIN = {7'($urandom), op, x, y};
    for (int s = 1; s <= steps; s++) begin
      @(posedge Clock);
      #1;
      Run = 1'($urandom);
      DIN = din_s[s];
    end
    @(posedge Clock);
    #1;
    Run = 1'b0;
    DIN = 16'($urandom);
  endtask

  task automatic idle(input int n);
    Run = 1'b0;
    repeat (n) begin
      @(posedge Clock);
      #1;
      DIN = 16'($urandom);
    end
  endtask

  // start op R1,R2 and pull reset part-way into step at_step
  task automatic reset_mid(input logic [2:0] op, input int at_step);
    Run = 1'b1;
    DIN = {7'h0, op, 3'd1, 3'd2};
    repeat (at_step) begin
      @(posedge Clock);
      #1;
      Run = 1'($urandom);
      DIN = 16'($urandom);
    end
    #2;
    if (op == ST) chk("st_w_before_rst", W, 1);
    Resetn = 1'b0;
    #1;
    chk("rst_w", W, 0);
    chk("rst_done", Done, 0);
    chk("rst_bus", Bus, DIN);
    chk("rst_addr", ADDR, 0);
    chk("rst_dout", DOUT, 0);
    sb.delete();
    model_reset();
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
    Run    = 1'b0;
  endtask

  initial begin
    Resetn = 1'b0;
    Run    = 1'b0;
    DIN    = '0;
    model_reset();
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    @(posedge Clock);
    #1;
    chk("por_w", W, 0);
    chk("por_done", Done, 0);
    chk("por_addr", ADDR, 0);
    chk("por_dout", DOUT, 0);
    @(posedge Clock);
    #1;
    Resetn = 1'b1;

    // Run low: Done must stay low
    idle(5);

    // mvi / add / sub / wrap
    exec(MVI, 0, 0, 16'h0005);
    exec(MVI, 1, 0, 16'h0003);
    exec(ADD, 0, 1, 0);
    exec(SUB, 0, 1, 0);
    exec(MVI, 1, 0, 16'hFFFF);
    exec(ADD, 0, 1, 0);

    // and / mv
    exec(MVI, 0, 0, 16'h00F0);
    exec(MVI, 1, 0, 16'h0FF0);
    exec(AND, 0, 1, 0);
    exec(MV, 2, 0, 0);
    exec(ADD, 1, 1, 0);

    // st / ld
    exec(MVI, 0, 0, 16'h0003);
    exec(MVI, 1, 0, 16'hABCD);
    exec(ST, 1, 0, 0);
    exec(LD, 2, 0, 0);
    exec(LD, 0, 0, 0);
    exec(MV, 0, 0, 0);

    // reset mid-add, registers must read back zero
    reset_mid(ADD, 2);
    for (int k = 0; k < 8; k++) exec(MV, 3'(k), 3'(k), 0);

    // reset while store has W high
    exec(MVI, 1, 0, 16'h1234);
    reset_mid(ST, 3);

    // mvnz with G==0, then with G!=0
    exec(MVI, 1, 0, 16'h0007);
    exec(MVNZ, 3, 1, 0);
    exec(MV, 3, 3, 0);
    exec(MVI, 0, 0, 16'h0005);
    exec(MVI, 2, 0, 16'h0003);
    exec(ADD, 0, 2, 0);
    exec(MVNZ, 3, 1, 0);
    exec(MV, 3, 3, 0);

    idle(5);

    // randomized, mostly back-to-back
    for (int n = 0; n < 300; n++) begin
      exec(3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(4);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
